// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM: Moore outputs decoded from state, with the
// FETCH-cycle IR/PC load qualified by mem_ready and illegal opcodes trapped.
module multicycle_control #(
  parameter int unsigned     OP_W    = 3,
  parameter logic [OP_W-1:0] OP_R    = OP_W'(1),
  parameter logic [OP_W-1:0] OP_LW   = OP_W'(2),
  parameter logic [OP_W-1:0] OP_SW   = OP_W'(3),
  parameter logic [OP_W-1:0] OP_J    = OP_W'(4),
  parameter logic [OP_W-1:0] OP_BEQ  = OP_W'(5),
  parameter logic [OP_W-1:0] OP_BNE  = OP_W'(6),
  parameter logic [OP_W-1:0] OP_ADDI = OP_W'(7)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] opcode,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            pc_write_beq,
  output logic            pc_write_bne,
  output logic            iord,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            reg_write,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic [1:0]      pc_source,
  output logic            illegal_op,
  output logic [3:0]      state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_ADDIEX = 4'd8,
    S_ADDIWB = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [OP_W-1:0] op_q;

  // State register; opcode is latched on the DECODE edge for later dispatch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= opcode;
    end
  end

  // Next state and control outputs.
  always_comb begin
    state_d      = S_FETCH;
    pc_write     = 1'b0;
    pc_write_beq = 1'b0;
    pc_write_bne = 1'b0;
    iord         = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    reg_write    = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    alu_op       = 2'b00;
    pc_source    = 2'b00;
    illegal_op   = 1'b0;
    state        = 4'(state_q);

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        if (opcode == OP_R)                              state_d = S_EXEC;
        else if (opcode == OP_LW || opcode == OP_SW)     state_d = S_MEMADR;
        else if (opcode == OP_ADDI)                      state_d = S_ADDIEX;
        else if (opcode == OP_BEQ || opcode == OP_BNE)   state_d = S_BRANCH;
        else if (opcode == OP_J)                         state_d = S_JUMP;
        else                                             state_d = S_TRAP;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        state_d   = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_RWB;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a    = 1'b1;
        alu_op       = 2'b01;
        pc_source    = 2'b01;
        pc_write_beq = (op_q == OP_BEQ);
        pc_write_bne = (op_q == OP_BNE);
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      S_TRAP:  illegal_op = 1'b1;
      default: state_d = S_FETCH;
    endcase

    // Reset silences every control line immediately, aborting any access.
    if (!rst_n) begin
      pc_write     = 1'b0;
      pc_write_beq = 1'b0;
      pc_write_bne = 1'b0;
      iord         = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      ir_write     = 1'b0;
      reg_dst      = 1'b0;
      mem_to_reg   = 1'b0;
      reg_write    = 1'b0;
      alu_src_a    = 1'b0;
      alu_src_b    = 2'b00;
      alu_op       = 2'b00;
      pc_source    = 2'b00;
      illegal_op   = 1'b0;
      state        = 4'd0;
    end
  end

endmodule
